// File: rtl/adder_pkg.sv
// Shared types and helpers for the nibble-serial adder.
// Holds the FSM state encoding, nibble width and the WIDTH legality check.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

    // WIDTH must be a positive whole number of nibbles.
    function automatic bit width_ok(input int w);
        return (w >= NIBBLE_W) && ((w % NIBBLE_W) == 0);
    endfunction

endpackage

// File: rtl/nibble_add4.sv
// Combinational 4-bit ripple adder used once per RUN cycle.
// c_msb is the carry into bit 3, used for signed overflow detection.
module nibble_add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       c_msb
);

    logic [4:0] c;

    // Bit-by-bit ripple through the internal carry chain.
    always_comb begin
        c      = '0;
        sum    = '0;
        c[0]   = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout  = c[4];
        c_msb = c[3];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder processing one nibble per clock, valid/ready both sides.
// Optional signed-overflow output `ovf` enabled by defining NSA_OVF_FLAG_EN.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef NSA_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    generate
        if (!width_ok(WIDTH)) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    state_t                    state;
    logic [WIDTH-1:0]          a_sh;
    logic [WIDTH-1:0]          b_sh;
    logic [WIDTH-1:0]          sum_r;
    logic                      carry;
    logic [CW-1:0]             cnt;
    logic                      cout_r;
    logic [NIBBLE_W-1:0]       nib_sum;
    logic                      nib_cout;
    logic [WIDTH+NIBBLE_W-1:0] sum_cat;
    logic                      last;

`ifdef NSA_OVF_FLAG_EN
    logic                      nib_c_msb;
    logic                      ovf_r;
`else
    logic                      c_msb_unused;
`endif

    nibble_add4 u_add4 (
        .a     (a_sh[NIBBLE_W-1:0]),
        .b     (b_sh[NIBBLE_W-1:0]),
        .cin   (carry),
        .sum   (nib_sum),
        .cout  (nib_cout),
`ifdef NSA_OVF_FLAG_EN
        .c_msb (nib_c_msb)
`else
        .c_msb (c_msb_unused)
`endif
    );

    // New nibble enters at the top; the sum register slides right by one nibble.
    assign sum_cat = {nib_sum, sum_r};
    assign last    = (cnt == CW'(NIBBLES - 1));

    // FSM, shift registers, carry register and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            cout_r <= 1'b0;
`ifdef NSA_OVF_FLAG_EN
            ovf_r  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_r <= sum_cat[WIDTH+NIBBLE_W-1:NIBBLE_W];
                    a_sh  <= a_sh >> NIBBLE_W;
                    b_sh  <= b_sh >> NIBBLE_W;
                    carry <= nib_cout;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        cout_r <= nib_cout;
`ifdef NSA_OVF_FLAG_EN
                        ovf_r  <= nib_c_msb ^ nib_cout;
`endif
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign sum       = sum_r;
    assign cout      = cout_r;
`ifdef NSA_OVF_FLAG_EN
    assign ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16).
// Checks ovf only when NSA_OVF_FLAG_EN is defined.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
`ifdef NSA_OVF_FLAG_EN
    logic        ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs[3];

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef NSA_OVF_FLAG_EN
        ,
        .ovf       (ovf)
`endif
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the whole operands.
    task automatic model(input logic [15:0] x, input logic [15:0] y, input logic c,
                         output logic [15:0] s, output logic co, output logic ov);
        logic [16:0] full;
        full = {1'b0, x} + {1'b0, y} + {16'd0, c};
        s    = full[15:0];
        co   = full[16];
        ov   = (x[15] == y[15]) && (s[15] != x[15]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one add; called #1 after a posedge. Returns after the output handshake
    // (if out_ready is high) or once out_valid is seen (if out_ready is low).
    task automatic do_add(input string name, input logic [15:0] x, input logic [15:0] y,
                          input logic c, input logic [15:0] es, input logic eco,
                          input logic eov, input bit scramble);
        int w;
        int lat;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        check({name, "_ready_wait"}, 32'(w < 20), 32'd1);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        cin      = c;
        tick();
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 20) begin
            if (scramble) begin
                a        = 16'($urandom);
                b        = 16'($urandom);
                cin      = 1'($urandom);
                in_valid = 1'($urandom);
            end
            tick();
            lat++;
        end
        in_valid = 1'b0;
        check({name, "_latency"}, 32'(lat), 32'd4);
        check({name, "_sum"}, 32'(sum), 32'(es));
        check({name, "_cout"}, 32'(cout), 32'(eco));
`ifdef NSA_OVF_FLAG_EN
        check({name, "_ovf"}, 32'(ovf), 32'(eov));
`else
        if (eov === 1'bx) $display("note: unexpected x in ovf expectation");
`endif
        if (out_ready) begin
            tick();
            check({name, "_post_valid"}, 32'(out_valid), 32'd0);
            check({name, "_post_ready"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        logic [15:0] rs;
        logic        rco;
        logic        rov;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [15:0] hs;
        logic        hco;

        vecs[0] = '{a: 16'h1234, b: 16'h0FCD, cin: 1'b0, s: 16'h2201, co: 1'b0, ov: 1'b0};
        vecs[1] = '{a: 16'hFFFF, b: 16'h0000, cin: 1'b1, s: 16'h0000, co: 1'b1, ov: 1'b0};
        vecs[2] = '{a: 16'h7FFF, b: 16'h0001, cin: 1'b0, s: 16'h8000, co: 1'b0, ov: 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_release_ready", 32'(in_ready), 32'd1);

        // Directed table.
        for (int i = 0; i < 3; i++) begin
            do_add($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                   vecs[i].s, vecs[i].co, vecs[i].ov, 1'b0);
        end

        // Backpressure: result held for 3 cycles with out_ready low.
        out_ready = 1'b0;
        do_add("bp", 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0);
        hs  = sum;
        hco = cout;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_valid_hold", 32'(out_valid), 32'd1);
            check("bp_sum_hold", 32'(sum), 32'(hs));
            check("bp_cout_hold", 32'(cout), 32'(hco));
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_accept_valid", 32'(out_valid), 32'd0);
        check("bp_accept_ready", 32'(in_ready), 32'd1);

        // Reset during the second RUN cycle.
        in_valid = 1'b1;
        a        = 16'hABCD;
        b        = 16'h1111;
        cin      = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("midrst_idle", 32'(in_ready), 32'd1);
        do_add("after_rst", 16'h0F0F, 16'hF0F1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

        // Inputs scrambled during RUN, then back-to-back adds.
        model(16'h8000, 16'h8000, 1'b1, rs, rco, rov);
        do_add("scr0", 16'h8000, 16'h8000, 1'b1, rs, rco, rov, 1'b1);
        check("b2b_ready", 32'(in_ready), 32'd1);
        model(16'h4321, 16'h5678, 1'b1, rs, rco, rov);
        do_add("scr1", 16'h4321, 16'h5678, 1'b1, rs, rco, rov, 1'b1);

        // Randomized adds against the reference model.
        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            if (i % 5 == 0) rb = ~ra;
            model(ra, rb, rc, rs, rco, rov);
            do_add($sformatf("rnd%0d", i), ra, rb, rc, rs, rco, rov, i[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
